// File: rtl/button_pulse_pkg.sv
// button_pulse_pkg: state encoding, default timing constants and helpers shared by button_pulse
package button_pulse_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 20000000;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with synchronous active-high reset, for asynchronous single-bit inputs
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic async_sig,
    output logic sync_sig
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) {sync_sig, meta} <= 2'b00;
        else {sync_sig, meta} <= {meta, async_sig};
    end

endmodule

// File: rtl/button_pulse.sv
// button_pulse: debounced button level plus single-cycle press strobe.
// Define BUTTON_PULSE_REPEAT_EN to add auto-repeat strobes while the button stays held.
module button_pulse
    import button_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_100Mhz,
    input  logic reset_in,
    input  logic btn_in,
    output logic btn_pulse,
    output logic btn_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("button_pulse: timing parameters must be >= 1");
    end

    logic sync;
    state_t state;
    logic [DW-1:0] cnt;

    sync_2ff u_sync (
        .clk      (clk_100Mhz),
        .reset    (reset_in),
        .async_sig(btn_in),
        .sync_sig (sync)
    );

`ifdef BUTTON_PULSE_REPEAT_EN
    localparam int RCW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);
    logic [RCW-1:0] rcnt;
    logic repeating;
    logic rpt_hit;
    assign rpt_hit = rcnt == (repeating ? PERIOD_LAST : DELAY_LAST);
`endif

    always_ff @(posedge clk_100Mhz) begin
        if (reset_in) begin
            state <= IDLE;
            cnt <= '0;
            btn_pulse <= 1'b0;
            btn_level <= 1'b0;
`ifdef BUTTON_PULSE_REPEAT_EN
            rcnt <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE:
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= HELD;
                            btn_pulse <= 1'b1;
                            btn_level <= 1'b1;
                        end else begin
                            state <= PRESS_WAIT;
                            cnt <= DW'(1);
                        end
                    end
                PRESS_WAIT:
                    if (!sync) begin
                        state <= IDLE;
                        cnt <= '0;
                    end else if (cnt == D_LAST) begin
                        state <= HELD;
                        cnt <= '0;
                        btn_pulse <= 1'b1;
                        btn_level <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                HELD:
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state <= IDLE;
                            btn_level <= 1'b0;
                        end else begin
                            state <= RELEASE_WAIT;
                            cnt <= DW'(1);
                        end
`ifdef BUTTON_PULSE_REPEAT_EN
                        rcnt <= '0;
                        repeating <= 1'b0;
                    end else if (rpt_hit) begin
                        // a strobe is never allowed two cycles running, even with 1-cycle timings
                        rcnt <= '0;
                        repeating <= 1'b1;
                        btn_pulse <= !btn_pulse;
                    end else begin
                        rcnt <= rcnt + 1'b1;
`endif
                    end
                RELEASE_WAIT:
                    if (sync) begin
                        state <= HELD;
                        cnt <= '0;
                    end else if (cnt == D_LAST) begin
                        state <= IDLE;
                        cnt <= '0;
                        btn_level <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/button_pulse.md
BUTTON_PULSE -- requirements
Module: button_pulse

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable synchronized samples needed to accept a level change (10 ms at 100 MHz); legal range >= 1.
REQ-002 Parameter REPEAT_DELAY, default 50000000, cycles in HELD before the first auto-repeat pulse; legal range >= 1.
REQ-003 Parameter REPEAT_PERIOD, default 20000000, cycles between subsequent auto-repeat pulses; legal range >= 1.
REQ-004 clk_100Mhz  input  1  sole clock, 100 MHz, all flops on rising edge.
REQ-005 reset_in  input  1  reset, synchronous, active-high.
REQ-006 btn_in  input  1  raw asynchronous push-button level, bouncy.
REQ-007 btn_pulse  output  1  single-cycle registered press strobe; drives the downstream mode counter's inc input.
REQ-008 btn_level  output  1  registered debounced button level.

Function
REQ-009 btn_in SHALL pass through a 2-flop synchronizer; only its output (sync) is used by the state machine.
REQ-010 States SHALL be IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-011 IDLE: sync=1 -> PRESS_WAIT with stable counter loaded to 1; else stay.
REQ-012 PRESS_WAIT: sync=0 -> IDLE, counter cleared; sync=1 with counter = DEBOUNCE_CYCLES-1 -> HELD; else counter increments.
REQ-013 With DEBOUNCE_CYCLES=1, IDLE SHALL go directly to HELD on the first sync=1 sample.
REQ-014 Entry into HELD from PRESS_WAIT or IDLE SHALL assert btn_pulse for exactly one cycle; btn_pulse first goes high at clock edge 2+DEBOUNCE_CYCLES after btn_in rises (first sampling edge = edge 1).
REQ-015 HELD: sync=0 -> RELEASE_WAIT with counter loaded to 1.
REQ-016 RELEASE_WAIT: sync=1 -> HELD, no pulse; DEBOUNCE_CYCLES consecutive sync=0 samples -> IDLE.
REQ-017 btn_level SHALL be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT, registered with the state.
REQ-018 Counters SHALL be sized $clog2(max parameter + 1) and never wrap; every stable-count path compares against the exact terminal value.
REQ-019 btn_pulse SHALL never be high in two consecutive cycles.

Reset
REQ-020 reset_in=1 at a rising edge SHALL clear both synchronizer flops, all counters and btn_pulse/btn_level, and force IDLE, overriding every other transition.
REQ-021 Reset mid-debounce SHALL abort without a pulse; a button held through reset SHALL produce one pulse after a full 2+DEBOUNCE_CYCLES edges following deassertion.

Configuration
REQ-022 Macro BUTTON_PULSE_REPEAT_EN defined: in HELD a repeat counter SHALL run and assert btn_pulse once after REPEAT_DELAY cycles in HELD, then every REPEAT_PERIOD cycles while HELD persists.
REQ-023 Leaving HELD SHALL clear the repeat counter; re-entry from RELEASE_WAIT restarts at REPEAT_DELAY.
REQ-024 Macro undefined: no repeat counter is synthesized and exactly one pulse per accepted press.

Structure
REQ-025 Package button_pulse_pkg SHALL hold the state enum and default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD.
REQ-026 Synchronizer SHALL be sub-module sync_2ff (clk, reset, async in, sync out), reusable for other buttons.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-027 Clean press, btn_in high 30 cycles -> single btn_pulse at edge 6; btn_level 1 from edge 6; btn_level 0 at edge 30+2+4=36.
REQ-028 Glitch, btn_in high 3 cycles then low -> no pulse, btn_level stays 0, state back to IDLE.
REQ-029 Release bounce, from HELD btn_in 0/0/1/0/0/0/0 -> no second pulse; btn_level stays 1 until 4th consecutive low sample.
REQ-030 reset_in pulsed while in PRESS_WAIT with btn_in held high -> outputs 0 during reset; one pulse at edge 6 after deassertion.
REQ-031 Repeat on, btn_in held long -> pulses at HELD entry, +10, +15, +20 cycles; repeat off -> only the entry pulse.
REQ-032 Two presses separated by 10 low cycles -> exactly two pulses, feeding a 2-bit mode counter from 0 to 2.
